// File: rtl/alu_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_rr_arbiter_pkg
// Shared definitions for the two-requester ALU arbiter:
//   - state_t : control FSM encoding (IDLE / EXEC / RESP)
//   - ID_W    : width of the requester id carried with each operation
// -----------------------------------------------------------------------------
package alu_rr_arbiter_pkg;

   localparam int ID_W = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage : alu_rr_arbiter_pkg

// File: rtl/alu_rr_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin grant.
// Ports:
//   valid [1:0] in   requesters with a pending operation
//   prio        in   index of the requester that wins a tie
//   grant [1:0] out  one-hot grant, all zero when nobody is valid
//   gid         out  index of the granted requester (0 when nobody is valid)
// -----------------------------------------------------------------------------
module rr_arb2
   import alu_rr_arbiter_pkg::*;
(
   input  logic [1:0]      valid,
   input  logic [ID_W-1:0] prio,
   output logic [1:0]      grant,
   output logic [ID_W-1:0] gid
);

   // A lone valid requester always wins; prio only breaks ties.
   always_comb begin
      gid = '0;
      if (valid == 2'b11) begin
         gid = prio;
      end else if (valid[1]) begin
         gid = 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_grant
         assign grant[gi] = valid[gi] && (gid == gi[ID_W-1:0]);
      end
   endgenerate

endmodule : rr_arb2

// File: rtl/alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// alu_rr_arbiter
// Shares one combinational ALU between two requesters using round-robin
// arbitration. Each requester has a valid/ready request channel carrying
// in1/in2/op; results return on one valid/ready response channel tagged
// with the owning requester's id.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   reqN_valid / reqN_ready    request handshake for requester N (N = 0, 1)
//   reqN_in1 / reqN_in2        operands  (DW bits)
//   reqN_op                    op-code   (OPW bits)
//   alu_in1 / alu_in2 / alu_op registered operands and op-code to the ALU
//   alu_out                    ALU result
//   rsp_valid / rsp_ready      response handshake
//   rsp_id / rsp_data          owning requester and result
// Sequence: accept in IDLE (cycle T), ALU settles in EXEC (T+1),
// response presented in RESP from T+2 until rsp_ready.
// -----------------------------------------------------------------------------
module alu_rr_arbiter
   import alu_rr_arbiter_pkg::*;
#(
   parameter int DW  = 32,
   parameter int OPW = 6
)(
   input  logic            clk,
   input  logic            rst,

   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [DW-1:0]   req0_in1,
   input  logic [DW-1:0]   req0_in2,
   input  logic [OPW-1:0]  req0_op,

   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [DW-1:0]   req1_in1,
   input  logic [DW-1:0]   req1_in2,
   input  logic [OPW-1:0]  req1_op,

   output logic [DW-1:0]   alu_in1,
   output logic [DW-1:0]   alu_in2,
   output logic [OPW-1:0]  alu_op,
   input  logic [DW-1:0]   alu_out,

   output logic            rsp_valid,
   output logic [ID_W-1:0] rsp_id,
   output logic [DW-1:0]   rsp_data,
   input  logic            rsp_ready
);

   state_t          state_reg,     state_next;
   logic [ID_W-1:0] prio_reg,      prio_next;
   logic [ID_W-1:0] id_reg,        id_next;
   logic [DW-1:0]   alu_in1_reg,   alu_in1_next;
   logic [DW-1:0]   alu_in2_reg,   alu_in2_next;
   logic [OPW-1:0]  alu_op_reg,    alu_op_next;
   logic            rsp_valid_reg, rsp_valid_next;
   logic [ID_W-1:0] rsp_id_reg,    rsp_id_next;
   logic [DW-1:0]   rsp_data_reg,  rsp_data_next;

   // Requester payloads gathered into arrays so the granted one is a
   // simple index by grant id.
   logic [1:0]      req_valid;
   logic [DW-1:0]   req_in1 [2];
   logic [DW-1:0]   req_in2 [2];
   logic [OPW-1:0]  req_op  [2];
   logic [1:0]      grant;
   logic [ID_W-1:0] gid;
   logic            accept;

   assign req_valid = {req1_valid, req0_valid};
   assign req_in1[0] = req0_in1;
   assign req_in1[1] = req1_in1;
   assign req_in2[0] = req0_in2;
   assign req_in2[1] = req1_in2;
   assign req_op[0]  = req0_op;
   assign req_op[1]  = req1_op;

   rr_arb2 u_arb (
      .valid (req_valid),
      .prio  (prio_reg),
      .grant (grant),
      .gid   (gid)
   );

   // Ready is held low while rst is asserted: the state register may
   // already read IDLE during a multi-cycle reset, but nothing may be
   // accepted until reset is released.
   assign accept     = (state_reg == ST_IDLE) && !rst && (grant != 2'b00);
   assign req0_ready = accept && grant[0];
   assign req1_ready = accept && grant[1];

   always_comb begin
      state_next     = state_reg;
      prio_next      = prio_reg;
      id_next        = id_reg;
      alu_in1_next   = alu_in1_reg;
      alu_in2_next   = alu_in2_reg;
      alu_op_next    = alu_op_reg;
      rsp_valid_next = rsp_valid_reg;
      rsp_id_next    = rsp_id_reg;
      rsp_data_next  = rsp_data_reg;

      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               alu_in1_next = req_in1[gid];
               alu_in2_next = req_in2[gid];
               alu_op_next  = req_op[gid];
               id_next      = gid;
               state_next   = ST_EXEC;
            end
         end
         ST_EXEC: begin
            // ALU inputs have been stable for a full cycle; capture result.
            rsp_data_next  = alu_out;
            rsp_valid_next = 1'b1;
            rsp_id_next    = id_reg;
            state_next     = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_next = 1'b0;
               // The requester just served drops to lowest priority.
               prio_next      = ~rsp_id_reg;
               state_next     = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         prio_reg      <= '0;
         id_reg        <= '0;
         alu_in1_reg   <= '0;
         alu_in2_reg   <= '0;
         alu_op_reg    <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_id_reg    <= '0;
         rsp_data_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         prio_reg      <= prio_next;
         id_reg        <= id_next;
         alu_in1_reg   <= alu_in1_next;
         alu_in2_reg   <= alu_in2_next;
         alu_op_reg    <= alu_op_next;
         rsp_valid_reg <= rsp_valid_next;
         rsp_id_reg    <= rsp_id_next;
         rsp_data_reg  <= rsp_data_next;
      end
   end

   assign alu_in1   = alu_in1_reg;
   assign alu_in2   = alu_in2_reg;
   assign alu_op    = alu_op_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_id    = rsp_id_reg;
   assign rsp_data  = rsp_data_reg;

endmodule : alu_rr_arbiter
